// File: rtl/pad_debounce_pkg.sv
// Shared constants and helpers for the pad debouncer.
package pad_debounce_pkg;

    // 1 ms of stable level at 36 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 36000;

    // Counter width able to hold 0..cycles
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One pad channel: 2-flop synchroniser, stability counter, accepted level and edge pulses.
// Edge pulses exist only when PAD_DEBOUNCE_EVENT_EN is defined.
module debounce_chan
    import pad_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic        RST_LEVEL       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_raw,
    output logic pad_db,
    output logic pad_rise,
    output logic pad_fall,
    output logic edge_c
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    // Only this flop reads the asynchronous pad level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= RST_LEVEL;
            sync_q2 <= RST_LEVEL;
        end else begin
            sync_q1 <= pad_raw;
            sync_q2 <= sync_q1;
        end
    end

    // New level has now been seen for DEBOUNCE_CYCLES consecutive cycles
    assign edge_c = (sync_q2 != pad_db) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_db <= RST_LEVEL;
            cnt    <= '0;
        end else if (sync_q2 == pad_db) begin
            cnt    <= '0;
        end else if (edge_c) begin
            pad_db <= sync_q2;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CW'(1);
        end
    end

`ifdef PAD_DEBOUNCE_EVENT_EN
    // Pulses register on the same edge as the pad_db update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pad_rise <= 1'b0;
            pad_fall <= 1'b0;
        end else begin
            pad_rise <= edge_c &  sync_q2;
            pad_fall <= edge_c & ~sync_q2;
        end
    end
`else
    assign pad_rise = 1'b0;
    assign pad_fall = 1'b0;
`endif

endmodule

// File: rtl/pad_debounce.sv
// N_PADS independent debounced pad channels plus per-channel sticky edge flags.
// Define PAD_DEBOUNCE_EVENT_EN to build the rise/fall pulses and sticky flags.
module pad_debounce
    import pad_debounce_pkg::*;
#(
    parameter int unsigned N_PADS          = 5,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic        RST_LEVEL       = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_PADS-1:0] pad_raw,
    output logic [N_PADS-1:0] pad_db,
    output logic [N_PADS-1:0] pad_rise,
    output logic [N_PADS-1:0] pad_fall,
    output logic [N_PADS-1:0] evt_sticky,
    input  logic [N_PADS-1:0] evt_clr
);

    logic [N_PADS-1:0] chan_edge_c;

    for (genvar i = 0; i < N_PADS; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_LEVEL       (RST_LEVEL)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .pad_raw  (pad_raw[i]),
            .pad_db   (pad_db[i]),
            .pad_rise (pad_rise[i]),
            .pad_fall (pad_fall[i]),
            .edge_c   (chan_edge_c[i])
        );
    end

`ifdef PAD_DEBOUNCE_EVENT_EN
    // Set wins over a simultaneous write-1-to-clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_sticky <= '0;
        end else begin
            evt_sticky <= (evt_sticky & ~evt_clr) | chan_edge_c;
        end
    end
`else
    logic unused_evt;

    assign evt_sticky = '0;
    assign unused_evt = ^{evt_clr, chan_edge_c};
`endif

endmodule

// File: tb/tb_pad_debounce.sv
// Randomised self-checking bench for pad_debounce with a sliding-window reference model.
`timescale 1ns/1ps
module tb_pad_debounce;

    localparam int unsigned N  = 5;
    localparam int unsigned DB = 4;
`ifdef PAD_DEBOUNCE_EVENT_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] pad_raw;
    logic [N-1:0] pad_db;
    logic [N-1:0] pad_rise;
    logic [N-1:0] pad_fall;
    logic [N-1:0] evt_sticky;
    logic [N-1:0] evt_clr;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    pad_debounce #(
        .N_PADS          (N),
        .DEBOUNCE_CYCLES (DB),
        .RST_LEVEL       (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pad_raw    (pad_raw),
        .pad_db     (pad_db),
        .pad_rise   (pad_rise),
        .pad_fall   (pad_fall),
        .evt_sticky (evt_sticky),
        .evt_clr    (evt_clr)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a level is accepted once the last DB synchronised samples all differ from it
    logic [N-1:0]  m_s1, m_s2, m_db, m_rise, m_fall, m_sticky;
    logic [DB-1:0] m_win [N];
    int unsigned   m_fill [N];

    always @(posedge clk) begin : model
        logic [N-1:0]  ndb, nrise, nfall;
        logic [DB-1:0] w;
        int unsigned   f;
        if (!rst_n) begin
            m_s1     <= '1;
            m_s2     <= '1;
            m_db     <= '1;
            m_rise   <= '0;
            m_fall   <= '0;
            m_sticky <= '0;
            for (int c = 0; c < N; c++) begin
                m_win[c]  <= '0;
                m_fill[c] <= 0;
            end
        end else begin
            ndb   = m_db;
            nrise = '0;
            nfall = '0;
            for (int c = 0; c < N; c++) begin
                w = {m_win[c][DB-2:0], m_s2[c]};
                f = (m_fill[c] < DB) ? m_fill[c] + 1 : DB;
                if (f == DB && w == {DB{~m_db[c]}}) begin
                    ndb[c] = m_s2[c];
                    if (m_s2[c]) nrise[c] = 1'b1;
                    else         nfall[c] = 1'b1;
                end
                m_win[c]  <= w;
                m_fill[c] <= f;
            end
            m_s1 <= pad_raw;
            m_s2 <= m_s1;
            m_db <= ndb;
            if (EV) begin
                m_rise   <= nrise;
                m_fall   <= nfall;
                m_sticky <= (m_sticky & ~evt_clr) | nrise | nfall;
            end else begin
                m_rise   <= '0;
                m_fall   <= '0;
                m_sticky <= '0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_db",     pad_db,     m_db);
            check("model_rise",   pad_rise,   m_rise);
            check("model_fall",   pad_fall,   m_fall);
            check("model_sticky", evt_sticky, m_sticky);
        end
    end

    int hold [N];

    initial begin
        rst_n   = 1'b0;
        pad_raw = '1;
        evt_clr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_db", pad_db, 5'h1F);
        check("rst_rise", pad_rise, 5'h00);
        check("rst_fall", pad_fall, 5'h00);
        check("rst_sticky", evt_sticky, 5'h00);
        repeat (100) @(negedge clk);
        check("idle_db", pad_db, 5'h1F);
        check("idle_sticky", evt_sticky, 5'h00);

        // Channel 0 falls: accepted on the 6th edge after the change
        pad_raw[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) check("fall_not_early", pad_db, 5'h1F);
        end
        check("fall_db", pad_db, 5'h1E);
        check("fall_pulse", pad_fall, EV ? 5'h01 : 5'h00);
        check("fall_sticky", evt_sticky, EV ? 5'h01 : 5'h00);
        @(posedge clk); #1;
        check("fall_once", pad_fall, 5'h00);

        // Channel 1 glitch shorter than the debounce window
        @(negedge clk);
        pad_raw[1] = 1'b0;
        repeat (3) @(negedge clk);
        pad_raw[1] = 1'b1;
        repeat (12) @(negedge clk);
        check("glitch_db", pad_db, 5'h1E);
        check("glitch_sticky", evt_sticky, EV ? 5'h01 : 5'h00);

        // Channels 2 and 4 together
        pad_raw[2] = 1'b0;
        pad_raw[4] = 1'b0;
        for (int k = 1; k <= 6; k++) begin @(posedge clk); #1; end
        check("multi_fall", pad_fall, EV ? 5'h14 : 5'h00);
        check("multi_fall_db", pad_db, 5'h0A);
        repeat (4) @(negedge clk);
        pad_raw[2] = 1'b1;
        pad_raw[4] = 1'b1;
        for (int k = 1; k <= 6; k++) begin @(posedge clk); #1; end
        check("multi_rise", pad_rise, EV ? 5'h14 : 5'h00);
        check("multi_rise_db", pad_db, 5'h1E);

        // Clear collides with a new accepted edge on channel 0
        @(negedge clk);
        evt_clr = 5'h1F;
        @(negedge clk);
        evt_clr = 5'h00;
        check("clr_all", evt_sticky, 5'h00);
        pad_raw[0] = 1'b1;
        for (int k = 1; k <= 5; k++) @(posedge clk);
        @(negedge clk);
        evt_clr[0] = 1'b1;
        @(posedge clk); #1;
        check("clr_vs_set_rise", pad_rise, EV ? 5'h01 : 5'h00);
        check("clr_vs_set_sticky", evt_sticky, EV ? 5'h01 : 5'h00);
        check("clr_vs_set_db", pad_db, 5'h1F);
        @(posedge clk); #1;
        check("clr_alone", evt_sticky, 5'h00);
        @(negedge clk);
        evt_clr = '0;

        // Reset in the middle of channel 3's count
        pad_raw[3] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b0;
        pad_raw[3] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rst_mid_db", pad_db, 5'h1F);
            check("rst_mid_fall", pad_fall, 5'h00);
        end

        // Random pad activity, clears and occasional resets
        for (int c = 0; c < N; c++) hold[c] = 0;
        repeat (3000) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    pad_raw[c] = 1'($urandom_range(0, 1));
                    hold[c]    = int'($urandom_range(1, 9));
                end
                hold[c]--;
            end
            evt_clr = N'($urandom & $urandom & $urandom);
            rst_n   = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        evt_clr = '0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
